branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DBITS, default 32, datapath and PC width.
REQ-002 SHALL have parameter BTBBITS, default 6, BTB index width (2^BTBBITS entries).
REQ-003 SHALL have parameter HISTBITS, default 8, global-history width and PHT index width (2^HISTBITS counters).
REQ-004 SHALL have parameter CNTBITS, default 2, PHT saturating-counter width (>=2).
REQ-005 SHALL have parameter STATBITS, default 16, statistics counter width.
REQ-006 SHALL have ports: clk  in  1  sole clock, all state on posedge.
REQ-007 RESET_N  in  1  reset, asynchronous, active-low.
REQ-008 pc_FE  in  DBITS  fetch PC, word-aligned.
REQ-009 stall_FE  in  1  fetch stalled; suppresses speculative history update.
REQ-010 pred_taken_FE  out  1  predicted taken.
REQ-011 pcpred_FE  out  DBITS  predicted next PC.
REQ-012 ghr_FE  out  HISTBITS  history snapshot carried down the pipe with the instruction.
REQ-013 upd_valid_EX  in  1  branch/jump resolved in EX this cycle.
REQ-014 upd_pc_EX, upd_target_EX  in  DBITS  resolved instruction PC and taken target.
REQ-015 upd_isjmp_EX, upd_taken_EX, upd_mispred_EX  in  1 each  unconditional jump, actual outcome, misprediction flag.
REQ-016 upd_ghr_EX  in  HISTBITS  ghr_FE snapshot from prediction time.
REQ-017 br_count, mispred_count  out  STATBITS each  resolved-branch and mispredict counts.

Function
REQ-018 BTB entry: valid, tag = PC[DBITS-1:BTBBITS+2], target, isjmp; index = PC[BTBBITS+1:2].
REQ-019 hit_FE = valid & tag match at pc_FE index.
REQ-020 PHT index = PC[HISTBITS+1:2] XOR history; lookup uses current GHR, update uses upd_ghr_EX.
REQ-021 pred_taken_FE = hit_FE & (isjmp | PHT counter MSB); combinational, zero-cycle latency.
REQ-022 pcpred_FE = pred_taken_FE ? BTB target : pc_FE + 4, modulo 2^DBITS.
REQ-023 ghr_FE = current GHR.
REQ-024 GHR priority per posedge: (1) upd_valid_EX & upd_mispred_EX: conditional -> {upd_ghr_EX[HISTBITS-2:0], upd_taken_EX}; jump -> upd_ghr_EX; (2) else !stall_FE & hit_FE & !isjmp -> {GHR[HISTBITS-2:0], pred_taken_FE}; (3) else hold.
REQ-025 On upd_valid_EX & upd_taken_EX: BTB entry at upd_pc_EX index written valid=1, tag, upd_target_EX, upd_isjmp_EX (overwrites any alias).
REQ-026 On upd_valid_EX & !upd_taken_EX: BTB unchanged.
REQ-027 On upd_valid_EX & !upd_isjmp_EX: PHT counter saturating +1 if taken, -1 if not; never wraps past 0 or 2^CNTBITS-1.
REQ-028 Jumps SHALL NOT modify PHT.
REQ-029 Same-cycle lookup and update of same BTB/PHT entry: lookup returns pre-update value; update visible next cycle.
REQ-030 br_count +1 per upd_valid_EX; mispred_count +1 per upd_valid_EX & upd_mispred_EX; both saturate at all-ones.
REQ-031 Inputs with upd_valid_EX=0 SHALL have no effect.

Reset
REQ-032 RESET_N low SHALL immediately, independent of clk: clear all BTB valid bits, set every PHT counter to 2^(CNTBITS-1)-1 (weakly not-taken), GHR=0, br_count=mispred_count=0.
REQ-033 While RESET_N low: pred_taken_FE=0, pcpred_FE=pc_FE+4, ghr_FE=0.
REQ-034 Reset asserted mid-update SHALL discard that update; first update honoured at first posedge after RESET_N high.

Verification
REQ-035 Post-reset, pc_FE=0x100 -> pred_taken_FE=0, pcpred_FE=0x104, ghr_FE=0, counts 0.
REQ-036 Update pc=0x200, isjmp=1, taken=1, target=0x400; next cycle pc_FE=0x200 -> pred_taken_FE=1, pcpred_FE=0x400; PHT unchanged; br_count=1.
REQ-037 Conditional pc=0x120, target=0x100, taken=1, upd_ghr=0, twice -> counter 01->10->11; with GHR=0, pc_FE=0x120 -> pcpred_FE=0x100; then not-taken x2 -> 01, pcpred_FE=0x124.
REQ-038 After 0x120 installed, pc_FE=0x220 (same index, different tag) -> miss, pcpred_FE=0x224; taken update at 0x220 then evicts 0x120.
REQ-039 GHR=0xA5, hit on conditional with stall_FE=0 and same-cycle upd_mispred_EX=1, upd_ghr_EX=0x12, taken=1 -> GHR=0x25, mispred_count+1; stall_FE=1 with no update -> GHR held.
REQ-040 Drive 2^STATBITS+3 updates -> br_count=0xFFFF; RESET_N pulsed low between edges -> counters and valid bits clear before next posedge.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + gshare PHT fetch predictor with speculative global history
// and EX-stage repair/training, plus saturating resolved-branch statistics.
module branch_predictor #(
  parameter int DBITS    = 32,
  parameter int BTBBITS  = 6,
  parameter int HISTBITS = 8,
  parameter int CNTBITS  = 2,
  parameter int STATBITS = 16
) (
  input  logic                clk,
  input  logic                RESET_N,
  input  logic [DBITS-1:0]    pc_FE,
  input  logic                stall_FE,
  output logic                pred_taken_FE,
  output logic [DBITS-1:0]    pcpred_FE,
  output logic [HISTBITS-1:0] ghr_FE,
  input  logic                upd_valid_EX,
  input  logic [DBITS-1:0]    upd_pc_EX,
  input  logic [DBITS-1:0]    upd_target_EX,
  input  logic                upd_isjmp_EX,
  input  logic                upd_taken_EX,
  input  logic                upd_mispred_EX,
  input  logic [HISTBITS-1:0] upd_ghr_EX,
  output logic [STATBITS-1:0] br_count,
  output logic [STATBITS-1:0] mispred_count
);
  localparam int NB = 1 << BTBBITS;
  localparam int NP = 1 << HISTBITS;
  localparam int TW = DBITS - BTBBITS - 2;
  logic [NB-1:0]       valid_q;
  logic [NB-1:0]       jmp_q;
  logic [TW-1:0]       tag_q [NB];
  logic [DBITS-1:0]    tgt_q [NB];
  logic [CNTBITS-1:0]  pht_q [NP];
  logic [HISTBITS-1:0] ghr_q, ghr_d;
  logic [STATBITS-1:0] br_q, mis_q;
  logic [BTBBITS-1:0]  f_idx, u_idx;
  logic [HISTBITS-1:0] f_pht, u_pht;
  logic [CNTBITS-1:0]  u_cnt, cnt_d;
  logic                hit, unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc_EX[1:0]};
  assign f_idx = pc_FE[BTBBITS+1:2];
  assign u_idx = upd_pc_EX[BTBBITS+1:2];
  assign f_pht = pc_FE[HISTBITS+1:2] ^ ghr_q;
  assign u_pht = upd_pc_EX[HISTBITS+1:2] ^ upd_ghr_EX;
  assign hit = valid_q[f_idx] && tag_q[f_idx] == pc_FE[DBITS-1:BTBBITS+2];
  assign pred_taken_FE = hit && (jmp_q[f_idx] || pht_q[f_pht][CNTBITS-1]);
  assign pcpred_FE = pred_taken_FE ? tgt_q[f_idx] : pc_FE + DBITS'(4);
  assign ghr_FE = ghr_q;
  assign br_count = br_q;
  assign mispred_count = mis_q;
  assign u_cnt = pht_q[u_pht];
  // EX repair of history outranks the speculative shift of the fetch prediction
  always_comb begin
    ghr_d = (upd_valid_EX && upd_mispred_EX) ?
              (upd_isjmp_EX ? upd_ghr_EX : {upd_ghr_EX[HISTBITS-2:0], upd_taken_EX}) :
            (!stall_FE && hit && !jmp_q[f_idx]) ? {ghr_q[HISTBITS-2:0], pred_taken_FE} : ghr_q;
    cnt_d = upd_taken_EX ? (&u_cnt ? u_cnt : u_cnt + CNTBITS'(1))
                         : (|u_cnt ? u_cnt - CNTBITS'(1) : u_cnt);
  end
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      ghr_q   <= '0;
      valid_q <= '0;
      br_q    <= '0;
      mis_q   <= '0;
      for (int i = 0; i < NP; i++) pht_q[i] <= CNTBITS'((1 << (CNTBITS - 1)) - 1);
    end else begin
      ghr_q <= ghr_d;
      if (upd_valid_EX) begin
        if (~&br_q) br_q <= br_q + STATBITS'(1);
        if (upd_mispred_EX && ~&mis_q) mis_q <= mis_q + STATBITS'(1);
        if (upd_taken_EX) valid_q[u_idx] <= 1'b1;
        if (!upd_isjmp_EX) pht_q[u_pht] <= cnt_d;
      end
    end
  end
  // Payload needs no reset: it is only observed through a set valid bit
  always_ff @(posedge clk) begin
    if (upd_valid_EX && upd_taken_EX) begin
      tag_q[u_idx] <= upd_pc_EX[DBITS-1:BTBBITS+2];
      tgt_q[u_idx] <= upd_target_EX;
      jmp_q[u_idx] <= upd_isjmp_EX;
    end
  end
endmodule
